// File: rtl/mem_access_if.sv
// CPU-side request/response signals plus the single-port RAM bus of the memory access unit.
// The unit takes the slave view; the control unit and RAM together take the master view.
interface mem_access_if;
  logic        req_read;
  logic        req_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  modport slave (
    input  req_read, req_write, addr, wdata, size, sign_ext, ram_rdata,
    output rdata, ready, busy, err, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output req_read, req_write, addr, wdata, size, sign_ext, ram_rdata,
    input  rdata, ready, busy, err, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-wide RAM with fixed read latency: aligned word stores,
// read-modify-write for half/byte stores, little-endian lane extraction for loads.
module mem_access_unit #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  mem_access_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_WAIT  = 3'd1;
  localparam logic [2:0] RMW_WAIT = 3'd2;
  localparam logic [2:0] WRITE    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        sign_q, sign_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        ram_we_q, ram_we_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    case (bus.size)
      SZ_WORD: misaligned = (bus.addr[1:0] != 2'b00);
      SZ_HALF: misaligned = bus.addr[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  // During RMW_WAIT ram_wdata_q still holds the raw store data; it is merged into the read word.
  always_comb begin
    byte_sel = bus.ram_rdata[8*lane_q +: 8];
    half_sel = lane_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    case (size_q)
      SZ_HALF: load_val = {{16{sign_q & half_sel[15]}}, half_sel};
      SZ_BYTE: load_val = {{24{sign_q & byte_sel[7]}}, byte_sel};
      default: load_val = bus.ram_rdata;
    endcase
    merged = bus.ram_rdata;
    if (size_q == SZ_HALF) merged[16*lane_q[1] +: 16] = ram_wdata_q[15:0];
    else                   merged[8*lane_q +: 8]      = ram_wdata_q[7:0];
  end

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    lane_d      = lane_q;
    sign_d      = sign_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ready_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_write || bus.req_read) begin
          size_d = bus.size;
          lane_d = bus.addr[1:0];
          sign_d = bus.sign_ext;
          if (misaligned) begin
            state_d = DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            ram_addr_d = {bus.addr[31:2], 2'b00};
            // A write wins over a simultaneous read; the read is simply dropped.
            if (bus.req_write) begin
              ram_wdata_d = bus.wdata;
              if (bus.size == SZ_WORD) begin
                ram_we_d = 1'b1;
                ready_d  = 1'b1;
                state_d  = DONE;
              end else begin
                cnt_d   = 2'(READ_LAT);
                state_d = RMW_WAIT;
              end
            end else begin
              cnt_d   = 2'(READ_LAT);
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = load_val;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RMW_WAIT: begin
        if (cnt_q == 2'd0) begin
          ram_wdata_d = merged;
          state_d     = WRITE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      WRITE: begin
        ram_we_d = 1'b1;
        ready_d  = 1'b1;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments; reset is synchronous and wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      size_q      <= SZ_WORD;
      lane_q      <= 2'd0;
      sign_q      <= 1'b0;
      rdata_q     <= 32'd0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
      ram_we_q    <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      sign_q      <= sign_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, RAM read latency in cycles from ram_addr valid to ram_rdata valid; legal values 1..3.
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req_read  in  1  load request from the control unit (its MemRead).
REQ-005 SHALL have port req_write  in  1  store request from the control unit (its MemWrite).
REQ-006 SHALL have port addr  in  32  byte address.
REQ-007 SHALL have port wdata  in  32  store data; byte and half stores use the low lane.
REQ-008 SHALL have port size  in  2  access size: 00 word, 01 half, 10 byte, 11 illegal.
REQ-009 SHALL have port sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-010 SHALL have port rdata  out  32  load result, extended per size/sign_ext.
REQ-011 SHALL have port ready  out  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  out  1  high in every non-IDLE state.
REQ-013 SHALL have port err  out  1  one-cycle pulse, coincident with ready, on misaligned or illegal access.
REQ-014 SHALL have ports ram_addr out 32 (word-aligned, bits 1:0 = 0), ram_wdata out 32, ram_we out 1, ram_rdata in 32.

Function
REQ-015 SHALL implement states IDLE, RD_WAIT, RMW_WAIT, WRITE, DONE; all outputs registered.
REQ-016 SHALL sample requests only in IDLE; requests in any other state are ignored, with no queueing.
REQ-017 If req_read and req_write are both high in IDLE, the write SHALL win and the read SHALL be dropped.
REQ-018 Misaligned cases SHALL be: word with addr[1:0]!=0; half with addr[0]!=0; size=11. For these, go to DONE, pulse ready+err, no ram_we, rdata unchanged.
REQ-019 Word store: ram_addr={addr[31:2],00}, ram_wdata=wdata, ram_we=1 for exactly one cycle after the accept edge E0; ready in that same cycle.
REQ-020 Load: enter RD_WAIT at E0 with counter=READ_LAT; capture ram_rdata when the counter expires; ready high after edge E(READ_LAT+1).
REQ-021 Load lane extraction SHALL be little-endian: byte lane addr[1:0] (lane0=bits 7:0); half lane addr[1] (0=bits 15:0).
REQ-022 Half/byte store SHALL be read-modify-write: RMW_WAIT reads the word; WRITE replaces only the addressed lane with wdata low bits, with ram_we=1 for one cycle; ready in that same cycle, after edge E(READ_LAT+2).
REQ-023 DONE SHALL last exactly one cycle (ready=1, requests not sampled), then return to IDLE.
REQ-024 A request held high after ready SHALL be accepted again as a new access.
REQ-025 ram_we SHALL never be high outside WRITE or the word-store cycle.

Reset
REQ-026 Reset SHALL have priority over all transitions; on reset: state IDLE, rdata=0, ready=0, busy=0, err=0, ram_we=0, ram_addr=0, ram_wdata=0, counter=0.
REQ-027 Reset mid-operation SHALL abandon the access: no ram_we after the reset edge, no ready pulse.

Verification
REQ-028 Word load, READ_LAT=1: addr=0x10, RAM word 0x8899AABB -> rdata=0x8899AABB, ready=1 for one cycle, 2 cycles after accept.
REQ-029 Byte load, sign_ext=1: addr=0x13, RAM word 0x80112233 -> rdata=0xFFFFFF80; with sign_ext=0 -> 0x00000080.
REQ-030 Half store: addr=0x12, wdata=0x0000BEEF, RAM word 0x11223344 -> single ram_we with ram_wdata=0xBEEF3344, ready 3 cycles after accept (READ_LAT=1).
REQ-031 Misaligned word load: addr=0x21 -> err=1 and ready=1 in the same cycle, ram_we never asserted, rdata unchanged.
REQ-032 Simultaneous req_read=req_write=1, size=00, addr=0x40, wdata=0xCAFEF00D -> word write performed, no read data captured.
REQ-033 Reset asserted in RMW_WAIT -> busy=0 next cycle, ram_we stays 0, no ready pulse, next request accepted normally.
